// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-facing bundle for alu_op_sequencer.
// The sequencer connects through the slave modport; the requester/ALU side connects through master.
interface alu_op_sequencer_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [1:0]       in_f;
    logic             in_acc;
    logic             acc_clr;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [1:0]       alu_f;
    logic [N-1:0]     alu_s;
    logic             alu_co;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_s;
    logic             out_co;
    logic             out_zero;
    logic             out_ovf;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_a, in_b, in_f, in_acc, acc_clr, alu_s, alu_co, out_ready,
        output in_ready, alu_a, alu_b, alu_f, out_valid, out_s, out_co, out_zero,
               out_ovf, acc, op_count
    );

    modport master (
        output in_valid, in_a, in_b, in_f, in_acc, acc_clr, alu_s, alu_co, out_ready,
        input  in_ready, alu_a, alu_b, alu_f, out_valid, out_s, out_co, out_zero,
               out_ovf, acc, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered operand launch and result capture around an external ripple ALU,
// with an accumulator for chained operations and a saturating completion counter.
module alu_op_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state, nxt_state;
    logic             accept, capture, done;
    logic [N-1:0]     alu_a_r, alu_b_r, out_s_r, acc_r;
    logic [1:0]       alu_f_r;
    logic             out_co_r, out_zero_r, out_ovf_r;
    logic [CNT_W-1:0] op_count_r;

    // Signed overflow from operand/result sign bits; only add and subtract define it.
    function automatic logic ovf_calc(input logic [1:0] f, input logic sa,
                                      input logic sb, input logic ss);
        logic r;
        r = 1'b0;
        case (f)
            2'b00:   r = (sa == sb) && (ss != sa);
            2'b01:   r = (sa != sb) && (ss != sa);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.in_valid;
                if (bus.in_valid) nxt_state = EXEC;
            end
            EXEC: begin
                capture   = 1'b1;
                nxt_state = HOLD;
            end
            HOLD: begin
                done = bus.out_ready;
                if (bus.out_ready) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Operand launch: acc is sampled before any same-edge clear takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r <= '0;
            alu_b_r <= '0;
            alu_f_r <= '0;
        end else if (accept) begin
            alu_a_r <= bus.in_acc ? acc_r : bus.in_a;
            alu_b_r <= bus.in_b;
            alu_f_r <= bus.in_f;
        end
    end

    // Result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_s_r    <= '0;
            out_co_r   <= 1'b0;
            out_zero_r <= 1'b0;
            out_ovf_r  <= 1'b0;
        end else if (capture) begin
            out_s_r    <= bus.alu_s;
            out_co_r   <= bus.alu_co;
            out_zero_r <= (bus.alu_s == '0);
            out_ovf_r  <= ovf_calc(alu_f_r, alu_a_r[N-1], alu_b_r[N-1], bus.alu_s[N-1]);
        end
    end

    // Clear has priority over the EXEC write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           acc_r <= '0;
        else if (bus.acc_clr) acc_r <= '0;
        else if (capture)     acc_r <= bus.alu_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    op_count_r <= '0;
        else if (done) op_count_r <= sat_inc(op_count_r);
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_f     = alu_f_r;
    assign bus.out_s     = out_s_r;
    assign bus.out_co    = out_co_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.acc       = acc_r;
    assign bus.op_count  = op_count_r;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one 16-bit-counter instance plus a 2-bit-counter
// twin fed the same requests, each with its own behavioural ALU.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.N(8), .CNT_W(16)) sif ();
    alu_op_sequencer_if #(.N(8), .CNT_W(2))  sif2 ();

    alu_op_sequencer #(.N(8), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(sif.slave));
    alu_op_sequencer #(.N(8), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(sif2.slave));

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] f);
        logic [8:0] r;
        case (f)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} + {1'b0, ~b} + 9'd1;
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    assign {sif.alu_co, sif.alu_s}   = alu_model(sif.alu_a, sif.alu_b, sif.alu_f);
    assign {sif2.alu_co, sif2.alu_s} = alu_model(sif2.alu_a, sif2.alu_b, sif2.alu_f);

    assign sif2.in_valid  = sif.in_valid;
    assign sif2.in_a      = sif.in_a;
    assign sif2.in_b      = sif.in_b;
    assign sif2.in_f      = sif.in_f;
    assign sif2.in_acc    = sif.in_acc;
    assign sif2.acc_clr   = sif.acc_clr;
    assign sif2.out_ready = sif.out_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and step through the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                         input logic use_acc);
        sif.in_valid = 1'b1;
        sif.in_a     = a;
        sif.in_b     = b;
        sif.in_f     = f;
        sif.in_acc   = use_acc;
        tick();
        sif.in_valid = 1'b0;
        sif.in_acc   = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!sif.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid_seen"}, sif.out_valid, 1'b1);
    endtask

    task automatic handshake();
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
    endtask

    initial begin
        sif.in_valid  = 1'b0;
        sif.in_a      = '0;
        sif.in_b      = '0;
        sif.in_f      = '0;
        sif.in_acc    = 1'b0;
        sif.acc_clr   = 1'b0;
        sif.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", sif.in_ready, 1'b1);
        chk("rst_out_valid", sif.out_valid, 1'b0);
        chk("rst_acc", sif.acc, 8'h00);
        chk("rst_op_count", sif.op_count, 16'd0);
        chk("rst_alu_a", sif.alu_a, 8'h00);
        chk("rst_out_s", sif.out_s, 8'h00);

        // Add with overflow, exact latency.
        issue(8'h7F, 8'h01, 2'b00, 1'b0);
        chk("add_alu_a", sif.alu_a, 8'h7F);
        chk("add_in_ready_exec", sif.in_ready, 1'b0);
        chk("add_valid_after_1", sif.out_valid, 1'b0);
        tick();
        chk("add_valid_after_2", sif.out_valid, 1'b1);
        chk("add_s", sif.out_s, 8'h80);
        chk("add_co", sif.out_co, 1'b0);
        chk("add_ovf", sif.out_ovf, 1'b1);
        chk("add_zero", sif.out_zero, 1'b0);
        chk("add_acc", sif.acc, 8'h80);
        handshake();
        chk("add_count", sif.op_count, 16'd1);
        chk("add_in_ready_after", sif.in_ready, 1'b1);

        // Subtract to zero.
        issue(8'h35, 8'h35, 2'b01, 1'b0);
        wait_result("sub");
        chk("sub_s", sif.out_s, 8'h00);
        chk("sub_co", sif.out_co, 1'b1);
        chk("sub_zero", sif.out_zero, 1'b1);
        chk("sub_ovf", sif.out_ovf, 1'b0);
        handshake();
        chk("sub_count", sif.op_count, 16'd2);
        chk("sat2_count_at_2", sif2.op_count, 2'd2);

        // Accumulator chaining.
        issue(8'h10, 8'h05, 2'b00, 1'b0);
        wait_result("chain1");
        chk("chain1_s", sif.out_s, 8'h15);
        handshake();
        issue(8'hAA, 8'h03, 2'b01, 1'b1);
        chk("chain2_alu_a", sif.alu_a, 8'h15);
        wait_result("chain2");
        chk("chain2_s", sif.out_s, 8'h12);
        chk("chain2_acc", sif.acc, 8'h12);
        handshake();
        chk("chain_count", sif.op_count, 16'd4);
        chk("sat2_count_at_4", sif2.op_count, 2'd3);

        // Backpressure with in_valid toggling and fresh operands.
        issue(8'h40, 8'h41, 2'b00, 1'b0);
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            sif.in_valid = i[0];
            sif.in_a     = 8'h01 + 8'(i);
            sif.in_b     = 8'h02;
            sif.in_f     = 2'b10;
            tick();
            chk("bp_valid", sif.out_valid, 1'b1);
            chk("bp_s", sif.out_s, 8'h81);
            chk("bp_ovf", sif.out_ovf, 1'b1);
            chk("bp_in_ready", sif.in_ready, 1'b0);
            chk("bp_alu_a", sif.alu_a, 8'h40);
            chk("bp_count", sif.op_count, 16'd4);
        end
        sif.in_valid = 1'b0;
        handshake();
        chk("bp_count_after", sif.op_count, 16'd5);
        chk("bp_out_valid_after", sif.out_valid, 1'b0);
        chk("bp_in_ready_after", sif.in_ready, 1'b1);

        // Clear colliding with the EXEC write-back.
        issue(8'h20, 8'h01, 2'b00, 1'b0);
        sif.acc_clr = 1'b1;
        tick();
        sif.acc_clr = 1'b0;
        chk("clr_valid", sif.out_valid, 1'b1);
        chk("clr_s", sif.out_s, 8'h21);
        chk("clr_acc", sif.acc, 8'h00);
        handshake();

        // Clear colliding with an in_acc accept: operand uses the old accumulator.
        issue(8'h07, 8'h00, 2'b00, 1'b0);
        wait_result("pre");
        handshake();
        chk("pre_acc", sif.acc, 8'h07);
        sif.acc_clr = 1'b1;
        issue(8'hEE, 8'h01, 2'b00, 1'b1);
        sif.acc_clr = 1'b0;
        chk("clracc_alu_a", sif.alu_a, 8'h07);
        chk("clracc_acc_cleared", sif.acc, 8'h00);
        wait_result("clracc");
        chk("clracc_s", sif.out_s, 8'h08);
        chk("clracc_acc", sif.acc, 8'h08);
        handshake();
        chk("final_count", sif.op_count, 16'd8);
        chk("sat2_count_final", sif2.op_count, 2'd3);

        // Reset in the middle of EXEC.
        issue(8'h11, 8'h22, 2'b00, 1'b0);
        chk("mid_in_ready_exec", sif.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", sif.out_valid, 1'b0);
        chk("mid_rst_in_ready", sif.in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_acc", sif.acc, 8'h00);
        chk("mid_rst_count", sif.op_count, 16'd0);
        chk("mid_rst_out_s", sif.out_s, 8'h00);
        chk("mid_rst_out_valid_after", sif.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
